// File: rtl/pkg_system_mdr.sv
// Shared types for the mdr unit and its host-side driver.
package pkg_system_mdr;

  localparam int DATA_W      = 16;
  localparam int MDR_TIMEOUT = 1024;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DATA_W-1:0] data_in_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_ROOT = 2'b10,
    OP_RSVD = 2'b11
  } op_select_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_ERR     = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_X,
    S_SEND_X,
    S_WAIT_Y,
    S_SEND_Y,
    S_WAIT_RES,
    S_RESP
  } drv_state_t;

  function automatic logic is_wait_state(input drv_state_t s);
    return (s == S_WAIT_X) || (s == S_WAIT_Y) || (s == S_WAIT_RES);
  endfunction

endpackage

// File: rtl/mdr_drv_timer.sv
// Wait-state watchdog: counts up from 0 while enabled, flags TIMEOUT-1 and saturates there.
module mdr_drv_timer
  import pkg_system_mdr::*;
#(
  parameter int TIMEOUT = MDR_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_driver.sv
// Host-side sequencer for the mdr unit: one job in flight, operand handshake, buffered response.
// state      | meaning
// S_IDLE     | ready for a job, latches op/x/y on request
// S_START    | one-cycle start pulse to the unit
// S_WAIT_X   | waiting for load_x
// S_SEND_X   | X on the bus with load pulse
// S_WAIT_Y   | waiting for load_y (unit error aborts)
// S_SEND_Y   | Y on the bus with load pulse (unit error aborts)
// S_WAIT_RES | waiting for ready or error
// S_RESP     | response held until consumer accepts
module mdr_driver
  import pkg_system_mdr::*;
#(
  parameter int DW      = DATA_W,
  parameter int TIMEOUT = MDR_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  op_select_t    i_req_op,
  input  logic [DW-1:0] i_req_x,
  input  logic [DW-1:0] i_req_y,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_result,
  output logic [DW-1:0] o_rsp_remainder,
  output rsp_status_t   o_rsp_status,
  output logic          o_mdr_start,
  output logic          o_mdr_load,
  output logic [DW-1:0] o_mdr_data,
  output op_select_t    o_mdr_op,
  input  logic          i_mdr_load_x,
  input  logic          i_mdr_load_y,
  input  logic          i_mdr_ready,
  input  logic          i_mdr_error,
  input  logic [DW-1:0] i_mdr_result,
  input  logic [DW-1:0] i_mdr_remainder
);

  drv_state_t    state, next_state;
  logic [DW-1:0] job_x, job_y;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic          cap_en, cap_data;
  rsp_status_t   cap_status;

  mdr_drv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    cap_data   = 1'b0;
    cap_status = RSP_OK;
    case (state)
      S_IDLE:   if (i_req_valid) next_state = S_START;
      S_START:  next_state = S_WAIT_X;
      S_WAIT_X: begin
        if (i_mdr_load_x) begin
          next_state = S_SEND_X;
        end else if (tmr_tc) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_TIMEOUT;
        end
      end
      S_SEND_X: next_state = S_WAIT_Y;
      S_WAIT_Y: begin
        // the unit checks operands at load time, so an error here ends the job
        if (i_mdr_error) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_ERR;
        end else if (i_mdr_load_y) begin
          next_state = S_SEND_Y;
        end else if (tmr_tc) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_TIMEOUT;
        end
      end
      S_SEND_Y: begin
        next_state = S_WAIT_RES;
        if (i_mdr_error) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_ERR;
        end
      end
      S_WAIT_RES: begin
        if (i_mdr_error) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_ERR;
        end else if (i_mdr_ready) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_data   = 1'b1;
        end else if (tmr_tc) begin
          next_state = S_RESP;
          cap_en     = 1'b1;
          cap_status = RSP_TIMEOUT;
        end
      end
      S_RESP:   if (i_rsp_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    tmr_en  = is_wait_state(state);
    tmr_clr = !tmr_en || (next_state != state);
  end

  // outputs are registered from next_state so they change on the same edge as state
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      job_x           <= '0;
      job_y           <= '0;
      o_req_ready     <= 1'b1;
      o_rsp_valid     <= 1'b0;
      o_rsp_result    <= '0;
      o_rsp_remainder <= '0;
      o_rsp_status    <= RSP_OK;
      o_mdr_start     <= 1'b0;
      o_mdr_load      <= 1'b0;
      o_mdr_data      <= '0;
      o_mdr_op        <= OP_MUL;
    end else begin
      state <= next_state;
      if (state == S_IDLE && i_req_valid) begin
        job_x <= i_req_x;
        job_y <= i_req_y;
      end
      o_req_ready <= (next_state == S_IDLE);
      o_rsp_valid <= (next_state == S_RESP);
      o_mdr_start <= (next_state == S_START);
      o_mdr_load  <= (next_state == S_SEND_X) || (next_state == S_SEND_Y);
      if (next_state == S_SEND_X) o_mdr_data <= job_x;
      if (next_state == S_SEND_Y) o_mdr_data <= job_y;
      if (next_state == S_START) begin
        o_mdr_op <= i_req_op;
      end else if (next_state == S_IDLE) begin
        o_mdr_op <= OP_MUL;
      end
      if (cap_en) begin
        o_rsp_status    <= cap_status;
        o_rsp_result    <= cap_data ? i_mdr_result    : '0;
        o_rsp_remainder <= cap_data ? i_mdr_remainder : '0;
      end
    end
  end

endmodule

// File: tb/tb_mdr_driver.sv
// Directed bench for mdr_driver with a small behavioural mdr unit driven from the stimulus thread.
module tb_mdr_driver;
  import pkg_system_mdr::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  op_select_t    req_op = OP_MUL;
  logic [DW-1:0] req_x = '0, req_y = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result, rsp_remainder;
  rsp_status_t   rsp_status;
  logic          mdr_start, mdr_load;
  logic [DW-1:0] mdr_data;
  op_select_t    mdr_op;
  logic          mdr_load_x = 1'b0, mdr_load_y = 1'b0;
  logic          mdr_ready = 1'b0, mdr_error = 1'b0;
  logic [DW-1:0] mdr_result = '0, mdr_remainder = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int n_loads  = 0;
  int n_valid_cycles = 0;
  int op_bad = 0;
  logic op_watch = 1'b0;
  logic [1:0] op_exp = 2'b00;

  always #5 clk = ~clk;

  mdr_driver #(.DW(DW), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_op        (req_op),
    .i_req_x         (req_x),
    .i_req_y         (req_y),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_result    (rsp_result),
    .o_rsp_remainder (rsp_remainder),
    .o_rsp_status    (rsp_status),
    .o_mdr_start     (mdr_start),
    .o_mdr_load      (mdr_load),
    .o_mdr_data      (mdr_data),
    .o_mdr_op        (mdr_op),
    .i_mdr_load_x    (mdr_load_x),
    .i_mdr_load_y    (mdr_load_y),
    .i_mdr_ready     (mdr_ready),
    .i_mdr_error     (mdr_error),
    .i_mdr_result    (mdr_result),
    .i_mdr_remainder (mdr_remainder)
  );

  always @(posedge clk) begin
    if (mdr_start) n_starts++;
    if (mdr_load)  n_loads++;
    if (rsp_valid) n_valid_cycles++;
  end

  always @(negedge clk) begin
    if (op_watch && (mdr_op !== op_exp)) op_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return mdr_start;
      1:       return mdr_load;
      default: return rsp_valid;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string tag, output int cyc);
    cyc = 0;
    while (!sig(sel) && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (!sig(sel)) check({tag, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  task automatic mdr_model(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           output logic [DW-1:0] r, output logic [DW-1:0] m);
    r = '0;
    m = '0;
    case (op)
      2'b00: r = DW'(x * y);
      2'b01: if (y != 0) begin r = x / y; m = x % y; end
      2'b10: begin
        for (int i = 0; i < 256; i++) if (i * i <= int'(x)) r = DW'(i);
        m = x - DW'(r * r);
      end
      default: ;
    endcase
  endtask

  task automatic send_req(input op_select_t op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_x = x;
    req_y = y;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_idle"}, req_ready, 1);
  endtask

  // full job against a unit that answers every request immediately
  task automatic run_job(input op_select_t op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] er, input logic [DW-1:0] erm,
                         input int hold, input string tag);
    int cyc, st0, ld0, bad;
    logic [DW-1:0] r, m;
    st0 = n_starts;
    ld0 = n_loads;
    send_req(op, x, y);
    check({tag, "_start_lat"}, mdr_start, 1);
    op_exp = op;
    op_watch = 1'b1;
    mdr_load_x = 1'b1;
    @(negedge clk);
    check({tag, "_start_pulse"}, mdr_start, 0);
    wait_sig(1, {tag, "_xload"}, cyc);
    check({tag, "_xdata"}, mdr_data, x);
    mdr_load_x = 1'b0;
    mdr_load_y = 1'b1;
    @(negedge clk);
    check({tag, "_load_pulse"}, mdr_load, 0);
    wait_sig(1, {tag, "_yload"}, cyc);
    check({tag, "_ydata"}, mdr_data, y);
    mdr_load_y = 1'b0;
    mdr_model(op, x, y, r, m);
    @(negedge clk);
    mdr_ready = 1'b1;
    mdr_result = r;
    mdr_remainder = m;
    @(negedge clk);
    mdr_ready = 1'b0;
    check({tag, "_rsp_lat"}, rsp_valid, 1);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_rem"}, rsp_remainder, erm);
    check({tag, "_status"}, rsp_status, RSP_OK);
    check({tag, "_busy"}, req_ready, 0);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== er || req_ready !== 1'b0) bad++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, bad, 0);
    op_watch = 1'b0;
    handshake(tag);
    check({tag, "_op_stable"}, op_bad, 0);
    check({tag, "_starts"}, n_starts - st0, 1);
    check({tag, "_loads"}, n_loads - ld0, 2);
  endtask

  initial begin
    int cyc, nv;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_start", mdr_start, 0);
    rst = 1'b0;

    run_job(OP_MUL, 16'd7, 16'd6, 16'd42, 16'd0, 0, "mul");
    run_job(OP_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 0, "div");

    // divide by zero: unit flags error right after the Y load
    send_req(OP_DIV, 16'd5, 16'd0);
    mdr_load_x = 1'b1;
    wait_sig(1, "err_xload", cyc);
    mdr_load_x = 1'b0;
    mdr_load_y = 1'b1;
    @(negedge clk);
    wait_sig(1, "err_yload", cyc);
    mdr_load_y = 1'b0;
    mdr_error = 1'b1;
    mdr_result = 16'hdead;
    mdr_remainder = 16'hbeef;
    @(negedge clk);
    mdr_error = 1'b0;
    check("err_valid", rsp_valid, 1);
    check("err_status", rsp_status, RSP_ERR);
    check("err_result", rsp_result, 0);
    check("err_rem", rsp_remainder, 0);
    handshake("err");

    run_job(OP_MUL, 16'd3, 16'd3, 16'd9, 16'd0, 10, "bp");

    // unit takes X but never asks for Y
    send_req(OP_MUL, 16'd1, 16'd2);
    mdr_load_x = 1'b1;
    wait_sig(1, "to_xload", cyc);
    mdr_load_x = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("to_latency", cyc, 17);
    check("to_status", rsp_status, RSP_TIMEOUT);
    check("to_result", rsp_result, 0);
    check("to_rem", rsp_remainder, 0);
    handshake("to");

    // reset while the job waits for a result
    send_req(OP_DIV, 16'd9, 16'd4);
    mdr_load_x = 1'b1;
    wait_sig(1, "rst_xload", cyc);
    mdr_load_x = 1'b0;
    mdr_load_y = 1'b1;
    @(negedge clk);
    wait_sig(1, "rst_yload", cyc);
    mdr_load_y = 1'b0;
    @(negedge clk);
    nv = n_valid_cycles;
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_req_ready", req_ready, 1);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_start", mdr_start, 0);
    check("mid_load", mdr_load, 0);
    check("mid_data", mdr_data, 0);
    check("mid_op", mdr_op, 0);
    check("mid_result", rsp_result, 0);
    check("mid_status", rsp_status, 0);
    mdr_ready = 1'b1;
    mdr_result = 16'd77;
    repeat (5) @(negedge clk);
    mdr_ready = 1'b0;
    rsp_ready = 1'b0;
    check("mid_no_rsp", n_valid_cycles - nv, 0);
    check("mid_idle", req_ready, 1);

    run_job(OP_ROOT, 16'd49, 16'd0, 16'd7, 16'd0, 0, "root");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench time limit");
  end

endmodule
